// File: rtl/divider_arbiter_if.sv
// divider_arbiter_if
// Purpose: bundles everything that passes between the requesters, the shared
//   divider and divider_arbiter into one interface.
// Requester side:
//   req, a_flat, b_flat  requests and operands (requester i at [i*W +: W])
//   ack                  one-hot grant pulse
// Divider side:
//   div_a, div_b         registered operands to the divider
//   div_start            start pulse to the divider
//   div_q                quotient from the divider
//   div_dvz, div_ovf     divide-by-zero and overflow flags from the divider
//   div_busy, div_valid  divider status
// Response side:
//   rsp_valid            response pulse
//   rsp_id               index of the requester being answered
//   rsp_q, rsp_dvz, rsp_ovf, rsp_tmo  captured result fields
//   busy                 arbiter is not idle
// Modports:
//   slave   the arbiter
//   master  the surrounding system (requesters plus divider)
interface divider_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 10
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_flat;
  logic [N_REQ*W-1:0] b_flat;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       div_a;
  logic [W-1:0]       div_b;
  logic               div_start;
  logic [W-1:0]       div_q;
  logic               div_dvz;
  logic               div_ovf;
  logic               div_busy;
  logic               div_valid;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [W-1:0]       rsp_q;
  logic               rsp_dvz;
  logic               rsp_ovf;
  logic               rsp_tmo;
  logic               busy;

  modport slave (
    input  req, a_flat, b_flat, div_q, div_dvz, div_ovf, div_busy, div_valid,
    output ack, div_a, div_b, div_start, rsp_valid, rsp_id, rsp_q,
           rsp_dvz, rsp_ovf, rsp_tmo, busy
  );

  modport master (
    output req, a_flat, b_flat, div_q, div_dvz, div_ovf, div_busy, div_valid,
    input  ack, div_a, div_b, div_start, rsp_valid, rsp_id, rsp_q,
           rsp_dvz, rsp_ovf, rsp_tmo, busy
  );
endinterface

// File: rtl/divider_arbiter.sv
// divider_arbiter
// Purpose: shares one unsigned Q6.4 fixed-point divider among N_REQ clients.
//   Requesters are granted round-robin. The granted operands are captured and
//   handed to the divider with a start pulse. The divider's result is then
//   returned tagged with the requester index. One operation is in flight at a time.
// Ports:
//   clk   single rising-edge clock
//   sclr  synchronous active-high reset (the divider shares it)
//   bus   divider_arbiter_if.slave. This modport carries:
//         - the requester handshake (req / a_flat / b_flat / ack)
//         - the divider handshake (div_*)
//         - the tagged response (rsp_*)
//         - busy
// Parameters:
//   N_REQ    number of requesters (2..8)
//   W        operand / quotient width
//   TIMEOUT  WAIT-state cycle limit, used only when DIV_TIMEOUT_EN is defined
// Configuration:
//   DIV_TIMEOUT_EN  when defined, an operation that does not complete within
//                   TIMEOUT WAIT cycles is aborted. Its response then carries
//                   rsp_tmo=1 and zeroed result fields.
//                   Otherwise WAIT waits indefinitely and rsp_tmo is tied low.
module divider_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 10,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              sclr,
  divider_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("divider_arbiter: unsupported N_REQ or TIMEOUT");
  end

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic            seen_busy;
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] ptr_next;
  logic            done;
  int              scan_idx;

`ifdef DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  // Round-robin pick: scan offsets from the highest down to zero, so the
  // requester nearest ptr (offset 0 first, wrapping) is written last and wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (bus.req[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  assign ptr_next = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  // A div_valid left over from the previous operation is still high when WAIT
  // starts. It only counts once the divider has been seen busy for this
  // operation. Divide-by-zero may finish without the divider ever going busy.
  assign done = bus.div_dvz | (bus.div_valid & seen_busy);

  assign bus.busy = (state != ST_IDLE);

`ifndef DIV_TIMEOUT_EN
  assign bus.rsp_tmo = 1'b0;
`endif

  // Main sequencer.
  // ack, div_start and rsp_valid are single-cycle pulses: they default low and
  // are raised only on the transition into the state that presents them.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      seen_busy     <= 1'b0;
      bus.ack       <= '0;
      bus.div_a     <= '0;
      bus.div_b     <= '0;
      bus.div_start <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_q     <= '0;
      bus.rsp_dvz   <= 1'b0;
      bus.rsp_ovf   <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      bus.rsp_tmo   <= 1'b0;
      tmo_cnt       <= '0;
`endif
    end else begin
      bus.ack       <= '0;
      bus.div_start <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            bus.div_a         <= bus.a_flat[grant_id*W +: W];
            bus.div_b         <= bus.b_flat[grant_id*W +: W];
            bus.rsp_id        <= grant_id;
            bus.ack[grant_id] <= 1'b1;
            ptr               <= ptr_next;
            state             <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus.div_start <= 1'b1;
          seen_busy     <= 1'b0;
`ifdef DIV_TIMEOUT_EN
          tmo_cnt       <= '0;
`endif
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.div_busy) seen_busy <= 1'b1;
          if (done) begin
            bus.rsp_q     <= bus.div_q;
            bus.rsp_dvz   <= bus.div_dvz;
            bus.rsp_ovf   <= bus.div_ovf;
`ifdef DIV_TIMEOUT_EN
            bus.rsp_tmo   <= 1'b0;
`endif
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end
`ifdef DIV_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.rsp_q     <= '0;
            bus.rsp_dvz   <= 1'b0;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_tmo   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter
// Purpose: self-checking bench for divider_arbiter. A behavioural divider answers
//   the arbiter with random latency. It keeps div_valid high from the previous
//   result until the next operation starts, so a stale valid is always present.
//   Requesters are driven with directed and random traffic. A reference model of
//   round-robin grants, Q6.4 division results and response timing predicts
//   every ack, start, response and busy value.
module tb_divider_arbiter;
  localparam int N_REQ   = 4;
  localparam int W       = 10;
  localparam int TIMEOUT = 16;

  typedef struct {
    int id;
    int a;
    int b;
    int q;
    bit dvz;
    bit ovf;
    bit tmo;
  } rsp_t;

  logic clk = 1'b0;
  logic sclr;

  always #5 clk = ~clk;

  divider_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  divider_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  int       compared   = 0;
  int       mismatched = 0;
  rsp_t     expQ[$];
  int       grantLog[$];
  logic [W-1:0] opA[N_REQ];
  logic [W-1:0] opB[N_REQ];
  int       refPtr;
  bit       nextEdgeIdle;
  bit       expRspNext;
  bit       prevCurRsp;
  bit       ackPrev;
  int       mode;
  bit       hangMode;
  bit       startPending;
  bit       divDvzPulse;
  int       divCnt;
  int       divA;
  int       divB;
  int       tmoLeft;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int refPick(input logic [N_REQ-1:0] r);
    for (int k = 0; k < N_REQ; k++)
      if (r[(refPtr + k) % N_REQ]) return (refPtr + k) % N_REQ;
    return -1;
  endfunction

  // Q6.4 / Q6.4 -> Q6.4: quotient = a * 16 / b, overflow past 10 bits.
  function automatic rsp_t refDivide(input int id, input int a, input int b);
    rsp_t e;
    e.id = id; e.a = a; e.b = b;
    e.q = 0; e.dvz = 1'b0; e.ovf = 1'b0; e.tmo = 1'b0;
`ifdef DIV_TIMEOUT_EN
    if (hangMode) begin
      e.tmo = 1'b1;
      return e;
    end
`endif
    if (b == 0) e.dvz = 1'b1;
    else begin
      e.q   = (a * 16) / b;
      e.ovf = (e.q > 1023);
    end
    return e;
  endfunction

  task automatic packOps();
    for (int i = 0; i < N_REQ; i++) begin
      bus.a_flat[i*W +: W] = opA[i];
      bus.b_flat[i*W +: W] = opB[i];
    end
  endtask

  function automatic logic [W-1:0] randOperand(input bit allowZero);
    int r;
    r = $urandom_range(0, 7);
    if (allowZero && r == 0) return '0;
    return W'($urandom_range(1, 1023) >> $urandom_range(0, 7));
  endfunction

  task automatic finishDiv();
    int qv;
    bus.div_valid = 1'b1;
    expRspNext    = 1'b1;
    if (divB == 0) begin
      bus.div_dvz = 1'b1;
      bus.div_q   = '0;
      divDvzPulse = 1'b1;
    end else begin
      qv          = (divA * 16) / divB;
      bus.div_ovf = (qv > 1023);
      bus.div_q   = qv[W-1:0];
    end
  endtask

  // One clock cycle, evaluated at the falling edge:
  // check what the last rising edge produced, advance the divider model,
  // then update the requesters.
  task automatic tickCycle();
    bit thisEdgeIdle;
    bit curExpRsp;
    int expId;
    logic [N_REQ-1:0] expAck;
    rsp_t e;
    @(negedge clk);
    thisEdgeIdle = nextEdgeIdle;
    curExpRsp    = expRspNext;
    expRspNext   = 1'b0;
    expAck       = '0;
    expId        = -1;
    if (thisEdgeIdle && bus.req != '0) begin
      expId         = refPick(bus.req);
      expAck[expId] = 1'b1;
    end
    if (expId >= 0 || bus.ack != '0) checkOutput("ack", 32'(bus.ack), 32'(expAck));
    if (expId >= 0) begin
      expQ.push_back(refDivide(expId, int'(opA[expId]), int'(opB[expId])));
      grantLog.push_back(expId);
      refPtr = (expId + 1) % N_REQ;
    end
    if (ackPrev || bus.div_start) begin
      checkOutput("div_start", 32'(bus.div_start), 32'(ackPrev));
      if (bus.div_start && expQ.size() > 0) begin
        checkOutput("div_a", 32'(bus.div_a), expQ[$].a);
        checkOutput("div_b", 32'(bus.div_b), expQ[$].b);
      end
    end
    if (curExpRsp || bus.rsp_valid) checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(curExpRsp));
    if (curExpRsp) begin
      if (expQ.size() == 0) checkOutput("rsp_no_request", 32'(1), 32'(0));
      else begin
        e = expQ.pop_front();
        checkOutput("rsp_id", 32'(bus.rsp_id), e.id);
        checkOutput("rsp_tmo", 32'(bus.rsp_tmo), 32'(e.tmo));
        checkOutput("rsp_dvz", 32'(bus.rsp_dvz), 32'(e.dvz));
        if (e.tmo) begin
          checkOutput("rsp_q_tmo", 32'(bus.rsp_q), 32'(0));
          checkOutput("rsp_ovf_tmo", 32'(bus.rsp_ovf), 32'(0));
        end else if (!e.dvz) begin
          checkOutput("rsp_ovf", 32'(bus.rsp_ovf), 32'(e.ovf));
          if (!e.ovf) checkOutput("rsp_q", 32'(bus.rsp_q), e.q);
        end
      end
    end
    nextEdgeIdle = (thisEdgeIdle && expId < 0) || prevCurRsp;
    prevCurRsp   = curExpRsp;
    checkOutput("busy", 32'(bus.busy), 32'(!nextEdgeIdle));
    ackPrev = (expId >= 0);

    // Divider model: responds to a start one cycle late, so the previous
    // result's div_valid is still up during the first WAIT cycle.
    if (divDvzPulse) begin
      bus.div_dvz = 1'b0;
      divDvzPulse = 1'b0;
    end
    if (bus.div_start) begin
      startPending = 1'b1;
      divA = int'(bus.div_a);
      divB = int'(bus.div_b);
`ifdef DIV_TIMEOUT_EN
      if (hangMode) tmoLeft = TIMEOUT - 1;
`endif
    end else begin
      if (startPending) begin
        startPending  = 1'b0;
        bus.div_valid = 1'b0;
        bus.div_ovf   = 1'b0;
        if (hangMode) begin
          bus.div_busy = 1'b1;
          divCnt       = 0;
        end else if (divB == 0) begin
          bus.div_busy = 1'b0;
          finishDiv();
        end else begin
          bus.div_busy = 1'b1;
          divCnt       = $urandom_range(1, 4);
        end
      end else if (divCnt > 0) begin
        divCnt--;
        if (divCnt == 0) begin
          bus.div_busy = 1'b0;
          finishDiv();
        end
      end
      if (tmoLeft > 0) begin
        tmoLeft--;
        if (tmoLeft == 0) expRspNext = 1'b1;
      end
    end

    // Requesters: mode 0 drops on ack, mode 1 random traffic,
    // mode 2 keeps every request up and reloads operands after each grant.
    for (int i = 0; i < N_REQ; i++) begin
      if (mode == 0) begin
        if (i == expId) bus.req[i] = 1'b0;
      end else if (mode == 2) begin
        if (i == expId) begin
          opA[i] = randOperand(1'b0);
          opB[i] = randOperand(1'b1);
        end
      end else begin
        if (i == expId) begin
          bus.req[i] = ($urandom_range(0, 3) == 0);
          opA[i] = randOperand(1'b0);
          opB[i] = randOperand(1'b1);
        end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b1;
          opA[i] = randOperand(1'b0);
          opB[i] = randOperand(1'b1);
        end else if (bus.req[i] && $urandom_range(0, 15) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
    packOps();
  endtask

  // Directed request from one client.
  task automatic applyStimulus(input int id, input int a, input int b);
    opA[id] = W'(a);
    opB[id] = W'(b);
    bus.req[id] = 1'b1;
    packOps();
  endtask

  task automatic runUntilIdle(input int maxCycles);
    int  n;
    bit  settled;
    n = 0;
    settled = 1'b0;
    while (!settled && n < maxCycles) begin
      tickCycle();
      n++;
      settled = (bus.req == '0) && (expQ.size() == 0) && nextEdgeIdle;
    end
    if (!settled) checkOutput("idle_within_bound", 32'(0), 32'(1));
  endtask

  task automatic applyReset();
    @(negedge clk);
    sclr          = 1'b1;
    bus.req       = '0;
    bus.div_q     = '0;
    bus.div_dvz   = 1'b0;
    bus.div_ovf   = 1'b0;
    bus.div_busy  = 1'b0;
    bus.div_valid = 1'b0;
    startPending  = 1'b0;
    divDvzPulse   = 1'b0;
    divCnt        = 0;
    tmoLeft       = 0;
    @(negedge clk);
    checkOutput("rst_ack", 32'(bus.ack), 32'(0));
    checkOutput("rst_div_start", 32'(bus.div_start), 32'(0));
    checkOutput("rst_div_a", 32'(bus.div_a), 32'(0));
    checkOutput("rst_div_b", 32'(bus.div_b), 32'(0));
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    checkOutput("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
    checkOutput("rst_rsp_q", 32'(bus.rsp_q), 32'(0));
    checkOutput("rst_rsp_dvz", 32'(bus.rsp_dvz), 32'(0));
    checkOutput("rst_rsp_ovf", 32'(bus.rsp_ovf), 32'(0));
    checkOutput("rst_rsp_tmo", 32'(bus.rsp_tmo), 32'(0));
    checkOutput("rst_busy", 32'(bus.busy), 32'(0));
    sclr         = 1'b0;
    expQ.delete();
    refPtr       = 0;
    nextEdgeIdle = 1'b1;
    expRspNext   = 1'b0;
    prevCurRsp   = 1'b0;
    ackPrev      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sclr       = 1'b1;
    bus.req    = '0;
    bus.a_flat = '0;
    bus.b_flat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    mode     = 0;
    hangMode = 1'b0;
    applyReset();

    // 12 / 0.25 = 48
    applyStimulus(0, 10'b0011000000, 10'b0000000100);
    runUntilIdle(50);
    checkOutput("t1_rsp_id", 32'(bus.rsp_id), 32'(0));
    checkOutput("t1_rsp_q", 32'(bus.rsp_q), 32'(10'b1100000000));
    checkOutput("t1_rsp_dvz", 32'(bus.rsp_dvz), 32'(0));

    // divide by zero
    applyStimulus(1, 10'b0011000000, 0);
    runUntilIdle(50);
    checkOutput("t2_rsp_id", 32'(bus.rsp_id), 32'(1));
    checkOutput("t2_rsp_dvz", 32'(bus.rsp_dvz), 32'(1));

    // 3.5 / 0.25 = 14, then 63 / 0.5 overflows
    applyStimulus(2, 10'b0000111000, 10'b0000000100);
    runUntilIdle(50);
    checkOutput("t4_rsp_q", 32'(bus.rsp_q), 32'(10'b0011100000));
    checkOutput("t4_rsp_ovf", 32'(bus.rsp_ovf), 32'(0));
    applyStimulus(3, 63 * 16, 8);
    runUntilIdle(50);
    checkOutput("t4_rsp_ovf_big", 32'(bus.rsp_ovf), 32'(1));

    // all four requesting continuously: strict rotation from 0
    applyReset();
    grantLog.delete();
    mode = 2;
    for (int i = 0; i < N_REQ; i++) applyStimulus(i, $urandom_range(1, 1023), $urandom_range(1, 63));
    for (int n = 0; n < 200 && grantLog.size() < 8; n++) tickCycle();
    bus.req = '0;
    mode = 0;
    runUntilIdle(50);
    checkOutput("rot_count", 32'(grantLog.size() >= 8), 32'(1));
    for (int i = 0; i < 8 && i < grantLog.size(); i++)
      checkOutput($sformatf("rot_order_%0d", i), grantLog[i], i % N_REQ);

    // random traffic
    mode = 1;
    repeat (1500) tickCycle();
    mode = 0;
    bus.req = '0;
    runUntilIdle(100);

    // reset in the middle of WAIT, then normal service resumes
    hangMode = 1'b1;
    applyStimulus(2, 300, 9);
    repeat (6) tickCycle();
    checkOutput("t5_busy_before_reset", 32'(bus.busy), 32'(1));
    applyReset();
    hangMode = 1'b0;
    repeat (3) tickCycle();
    applyStimulus(3, 500, 40);
    runUntilIdle(50);
    checkOutput("t5_rsp_id_after", 32'(bus.rsp_id), 32'(3));

    // divider that never completes
    applyReset();
    hangMode = 1'b1;
    applyStimulus(1, 100, 7);
`ifdef DIV_TIMEOUT_EN
    runUntilIdle(60);
    checkOutput("t6_rsp_tmo", 32'(bus.rsp_tmo), 32'(1));
    checkOutput("t6_rsp_q", 32'(bus.rsp_q), 32'(0));
`else
    repeat (100) tickCycle();
    checkOutput("t6_busy_held", 32'(bus.busy), 32'(1));
`endif
    hangMode = 1'b0;
    applyReset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
